// File: rtl/zb_demod_pkg.sv
// Shared widths, types and FSM encoding for the ZigBee demodulator datapath.
// The I/Q integrator imports everything from here.
package zb_demod_pkg;

    localparam int unsigned SMP_W  = 8;
    localparam int unsigned LO_W   = 4;
    localparam int unsigned SPC    = 25;
    localparam int unsigned ACC_W  = 18;
    // One extra bit so -(-128 * -8) stays exact.
    localparam int unsigned PROD_W = SMP_W + LO_W + 1;
    localparam int unsigned CNT_W  = $clog2(SPC);

    typedef logic signed [SMP_W-1:0]  smp_t;
    typedef logic signed [LO_W-1:0]   lo_t;
    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic signed [ACC_W-1:0]  acc_t;
    typedef logic [CNT_W-1:0]         cnt_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_e;

    function automatic prod_t mac_product(smp_t smp, lo_t lo, logic negate);
        prod_t p;
        p = prod_t'(smp) * prod_t'(lo);
        return negate ? -p : p;
    endfunction

endpackage

// File: rtl/iq_mac_lane.sv
// One mixer lane: registered LO product, integrate-and-dump accumulator and
// the held chip output. NEGATE selects the -(smp*lo) form used by the Q lane.
module iq_mac_lane
    import zb_demod_pkg::*;
#(
    parameter bit NEGATE = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic prod_en,
    input  smp_t smp,
    input  lo_t  lo,
    input  logic clear,
    input  logic acc_en,
    input  logic dump,
    output acc_t chip
);

    prod_t prod_q;
    acc_t  acc_q;
    acc_t  chip_q;
    acc_t  sum;

    assign sum  = acc_q + acc_t'(prod_q);
    assign chip = chip_q;

    // Product register only loads on accepted samples, so X on idle inputs never enters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prod_q <= '0;
        end else if (prod_en) begin
            prod_q <= mac_product(smp, lo, NEGATE);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q  <= '0;
            chip_q <= '0;
        end else begin
            if (clear || dump) begin
                acc_q <= '0;
            end else if (acc_en) begin
                acc_q <= sum;
            end
            if (dump) begin
                chip_q <= sum;
            end
        end
    end

endmodule

// File: rtl/iq_chip_integrator.sv
// Mixes ADC samples with the LO cos/sin words and integrates the I/Q products
// over one chip period, emitting one chip pair per window.
module iq_chip_integrator
    import zb_demod_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       chip_sync,
    input  logic       smp_valid,
    input  smp_t       smp_in,
    input  lo_t        cos_in,
    input  lo_t        sin_in,
    output acc_t       i_chip,
    output acc_t       q_chip,
    output logic       chip_valid,
    output logic [7:0] chip_cnt
);

    fsm_e       state_q;
    logic       s1_valid_q;
    cnt_t       cnt_q;
    logic       chip_valid_q;
    logic [7:0] chip_cnt_q;

    logic accept;
    logic flush;
    logic acc_en;
    logic dump;

    assign accept = enable & smp_valid;
    // Sync restarts the window; leaving RUN discards the partial window.
    assign flush  = (enable & chip_sync) | ((state_q == RUN) & ~enable);
    assign acc_en = s1_valid_q & ~flush;
    assign dump   = acc_en & (cnt_q == cnt_t'(SPC - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            s1_valid_q   <= 1'b0;
            cnt_q        <= '0;
            chip_valid_q <= 1'b0;
            chip_cnt_q   <= '0;
        end else begin
            state_q      <= enable ? RUN : IDLE;
            s1_valid_q   <= accept;
            chip_valid_q <= dump;
            if (flush || dump) begin
                cnt_q <= '0;
            end else if (acc_en) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (dump) begin
                chip_cnt_q <= chip_cnt_q + 1'b1;
            end
        end
    end

    assign chip_valid = chip_valid_q;
    assign chip_cnt   = chip_cnt_q;

    iq_mac_lane #(
        .NEGATE (1'b0)
    ) u_lane_i (
        .clk     (clk),
        .reset_n (reset_n),
        .prod_en (accept),
        .smp     (smp_in),
        .lo      (cos_in),
        .clear   (flush),
        .acc_en  (acc_en),
        .dump    (dump),
        .chip    (i_chip)
    );

    iq_mac_lane #(
        .NEGATE (1'b1)
    ) u_lane_q (
        .clk     (clk),
        .reset_n (reset_n),
        .prod_en (accept),
        .smp     (smp_in),
        .lo      (sin_in),
        .clear   (flush),
        .acc_en  (acc_en),
        .dump    (dump),
        .chip    (q_chip)
    );

endmodule

// File: tb/tb_iq_chip_integrator.sv
// Directed bench for iq_chip_integrator: a sample-level model pushes expected
// chip pairs into a scoreboard that a strobe monitor pops and compares.
module tb_iq_chip_integrator;
    import zb_demod_pkg::*;

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic       chip_sync;
    logic       smp_valid;
    smp_t       smp_in;
    lo_t        cos_in;
    lo_t        sin_in;
    acc_t       i_chip;
    acc_t       q_chip;
    logic       chip_valid;
    logic [7:0] chip_cnt;

    iq_chip_integrator dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .chip_sync  (chip_sync),
        .smp_valid  (smp_valid),
        .smp_in     (smp_in),
        .cos_in     (cos_in),
        .sin_in     (sin_in),
        .i_chip     (i_chip),
        .q_chip     (q_chip),
        .chip_valid (chip_valid),
        .chip_cnt   (chip_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int i;
        int q;
        int cnt;
        int edge_n;
    } exp_t;
    exp_t sb[$];

    // Sample-level model state: window sums, count, and the one pending product.
    int m_acc_i, m_acc_q, m_n, m_cnt;
    int m_pv, m_pi, m_pq;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_acc_i = 0; m_acc_q = 0; m_n = 0; m_cnt = 0;
        m_pv = 0; m_pi = 0; m_pq = 0;
        sb.delete();
    endtask

    task automatic step(input int en, input int sync, input int v,
                        input int s, input int c, input int sn);
        enable    = 1'(en);
        chip_sync = 1'(sync);
        smp_valid = 1'(v);
        smp_in    = v != 0 ? smp_t'(s)  : 'x;
        cos_in    = v != 0 ? lo_t'(c)   : 'x;
        sin_in    = v != 0 ? lo_t'(sn)  : 'x;
        if (en == 0) begin
            m_acc_i = 0; m_acc_q = 0; m_n = 0; m_pv = 0;
        end else begin
            if (sync != 0) begin
                m_acc_i = 0; m_acc_q = 0; m_n = 0;
            end else if (m_pv != 0) begin
                m_acc_i += m_pi;
                m_acc_q += m_pq;
                m_n++;
                if (m_n == SPC) begin
                    m_cnt = (m_cnt + 1) % 256;
                    sb.push_back('{m_acc_i, m_acc_q, m_cnt, cyc + 1});
                    m_acc_i = 0; m_acc_q = 0; m_n = 0;
                end
            end
            m_pv = v;
            m_pi = s * c;
            m_pq = -(s * sn);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input int s, input int c, input int sn);
        for (int k = 0; k < n; k++) step(1, 0, 1, s, c, sn);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1, 0, 0, 0, 0, 0);
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (sb.size() > 0 && sb[0].edge_n < cyc) begin
                check("missed_strobe", chip_valid, 1);
                void'(sb.pop_front());
            end
            if (chip_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("spurious_strobe", chip_valid, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("strobe_edge", cyc, mon_e.edge_n);
                    check("strobe_i", i_chip, mon_e.i);
                    check("strobe_q", q_chip, mon_e.q);
                    check("strobe_cnt", chip_cnt, mon_e.cnt);
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        enable = 1'b0; chip_sync = 1'b0; smp_valid = 1'b0;
        smp_in = '0; cos_in = '0; sin_in = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_i", i_chip, 0);
        check("rst_q", q_chip, 0);
        check("rst_valid", chip_valid, 0);
        check("rst_cnt", chip_cnt, 0);
        reset_n = 1'b1;
        idle(2);

        // Constant DC: two back-to-back windows.
        run(50, 10, 7, 0);
        idle(3);
        check("dc_i", i_chip, 1750);
        check("dc_q", q_chip, 0);
        check("dc_cnt", chip_cnt, 2);
        check("dc_valid_low", chip_valid, 0);

        // Extremes: full-scale products without wrap.
        run(25, -128, -8, -8);
        idle(3);
        check("ext_i", i_chip, 25600);
        check("ext_q", q_chip, -25600);
        check("ext_cnt", chip_cnt, 3);

        // Bubbles between every valid sample.
        for (int k = 0; k < 25; k++) begin
            step(1, 0, 1, 1, 1, 0);
            step(1, 0, 0, 0, 0, 0);
        end
        idle(2);
        check("bub_i", i_chip, 25);
        check("bub_cnt", chip_cnt, 4);

        // Sync mid-window: partial window dropped.
        run(10, 5, 2, 0);
        step(1, 1, 1, 5, 2, 0);
        run(24, 5, 2, 0);
        idle(3);
        check("sync_i", i_chip, 250);
        check("sync_cnt", chip_cnt, 5);

        // Sync on the dump edge: no strobe, outputs held.
        run(25, 3, 1, 0);
        step(1, 1, 0, 0, 0, 0);
        idle(3);
        check("syncdump_i", i_chip, 250);
        check("syncdump_cnt", chip_cnt, 5);
        run(25, 1, 1, 0);
        idle(3);
        check("after_sync_i", i_chip, 25);
        check("after_sync_cnt", chip_cnt, 6);

        // Enable dropped mid-window; sync and samples while idle are ignored.
        run(10, 9, 7, 7);
        step(0, 0, 1, 9, 7, 7);
        step(0, 1, 1, 9, 7, 7);
        step(0, 0, 1, 9, 7, 7);
        check("idle_cnt", chip_cnt, 6);
        run(25, 2, 3, -2);
        idle(3);
        check("en_i", i_chip, 150);
        check("en_q", q_chip, 100);
        check("en_cnt", chip_cnt, 7);

        // Async reset mid-window clears outputs before the next edge.
        run(10, 4, 4, 4);
        reset_n = 1'b0;
        #1;
        check("arst_i", i_chip, 0);
        check("arst_q", q_chip, 0);
        check("arst_cnt", chip_cnt, 0);
        check("arst_valid", chip_valid, 0);
        model_reset();
        enable = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        run(25, 1, 1, 1);
        idle(3);
        check("post_rst_i", i_chip, 25);
        check("post_rst_q", q_chip, -25);
        check("post_rst_cnt", chip_cnt, 1);

        check("sb_drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/iq_chip_integrator.md
Name: iq_chip_integrator

Overview:
- Downstream consumer of the cosine/sine local-oscillator generator in the ZigBee decoder.
- Mixes each incoming ADC sample with the 4-bit LO cos/sin words to form I/Q baseband products.
- Integrates the products over one chip period (integrate-and-dump) and presents one I/Q chip pair per period to the O-QPSK chip demapper.

Parameters:
- SMP_W, 8, ADC sample width (signed two's complement)
- LO_W, 4, cos/sin word width (signed two's complement, range -8..+7)
- SPC, 25, samples per chip (50 MHz clock / 2 Mchip/s)
- ACC_W, 18, accumulator and output width; must be >= SMP_W+LO_W+clog2(SPC)+1

Ports:
- clk  in  1  system clock, 50 MHz
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  block enable; when low, no samples are accepted
- chip_sync  in  1  restart integration window (from chip timing recovery)
- smp_valid  in  1  smp_in is valid this cycle
- smp_in  in  SMP_W  signed ADC sample
- cos_in  in  LO_W  signed LO cosine, from cossin_gen
- sin_in  in  LO_W  signed LO sine, from cossin_gen
- i_chip  out  ACC_W  signed integrated I for the last chip
- q_chip  out  ACC_W  signed integrated Q for the last chip
- chip_valid  out  1  one-cycle strobe: i_chip/q_chip updated
- chip_cnt  out  8  count of chips dumped, wraps 255->0

Behaviour:
- Reset (asynchronous, reset_n=0): all outputs 0; accumulators, sample counter and pipeline valid flags cleared; FSM enters IDLE.
- FSM states:
  - IDLE: enable=0; nothing accepted; outputs held.
  - RUN: enable=1.
  - IDLE->RUN on enable=1.
  - RUN->IDLE on enable=0; the partial window is discarded (accumulators, counter and pipeline cleared), and i_chip/q_chip/chip_cnt are held.
- Stage 1, registered: when smp_valid=1 in RUN:
  - p_i = smp_in*cos_in
  - p_q = -(smp_in*sin_in)
  - Full signed precision, SMP_W+LO_W+1 bits, so -(-128*-8) is exact.
  - Stage-1 valid flag = smp_valid.
- Stage 2: when stage-1 valid, acc += product and the sample counter increments. Cycles with smp_valid=0 are bubbles and do not advance the window.
- Dump: the product that brings the count to SPC is added, and on the same edge:
  - i_chip/q_chip are loaded with the final sums;
  - chip_valid=1 for one cycle;
  - chip_cnt increments;
  - accumulators and counter restart at 0.
- Latency: 2 clocks from the edge accepting the SPC-th sample to chip_valid high. Back-to-back windows with smp_valid held high produce a chip_valid every SPC cycles, with no lost samples.
- i_chip/q_chip hold their value between strobes.
- chip_sync=1 in RUN:
  - clears counter, accumulators and stage-1 valid, so in-flight products are dropped;
  - no chip_valid is generated for the partial window;
  - the sample presented with smp_valid in the same cycle is the first sample of the new window.
  - If chip_sync coincides with a dump edge, sync wins: no strobe, outputs unchanged.
- chip_sync while IDLE is ignored.
- Arithmetic: no saturation needed; the ACC_W rule guarantees no overflow. Default worst case: 25*1024 = 25600 < 2^17.
- X on cos_in/sin_in/smp_in with smp_valid=0 must not propagate.

Decomposition:
- Package zb_demod_pkg:
  - SMP_W, LO_W, SPC, ACC_W defaults;
  - typedefs smp_t, lo_t, prod_t, acc_t (signed);
  - FSM enum {IDLE, RUN}.
- One sub-module iq_mac_lane (multiply register + accumulator + dump register), instantiated twice. The Q lane has a negate parameter. The sample counter and FSM live in the top level.

Test Plan:
- Constant DC: smp_in=+10, cos_in=+7, sin_in=0, smp_valid=1 for 50 cycles -> two chip_valid strobes 25 cycles apart, first 2 clocks after the 25th sample; i_chip=1750, q_chip=0; chip_cnt=2.
- Extremes: smp_in=-128, cos_in=-8, sin_in=-8 -> i_chip=+25600, q_chip=-25600, no wrap.
- Bubbles: 25 valid samples (+1, cos=+1) interleaved with 1-cycle smp_valid=0 gaps -> exactly one strobe, i_chip=25, 2 clocks after the last valid sample.
- Sync mid-window: 10 samples (+5, cos=+2), then chip_sync with valid sample, then 24 more -> no strobe for the partial window; strobe with i_chip=250.
- Sync on dump edge: chip_sync asserted on the edge the 25th product is added -> no chip_valid; i_chip unchanged; chip_cnt unchanged.
- Reset and enable: reset_n low mid-window -> all outputs 0 immediately (async). enable dropped mid-window, then raised -> partial window discarded, next strobe reflects only post-enable samples.
